ps_ureg_xfer_ctl: RTL and testbench

Parametrised universal-register transfer controller for the program sequencer. It decodes universal-register (ureg) addresses from push/pop, immediate, DM-transfer and ureg-to-ureg instructions into read and write ports for three register groups: register file (RF), DAG and PS. Write ports are issued through a configurable write-back pipeline. A read-after-write hazard detector stalls issue while a conflicting write is still in flight. It sits between instruction decode and the RF, DAG and PS register banks.

---
 rtl/ps_ureg_xfer_ctl.sv | 184 ++++++++++++++++++
 tb/tb_ps_ureg_xfer_ctl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_ureg_xfer_ctl.sv
// Universal-register transfer controller: decodes ureg addresses from
// push/pop, immediate, DM-transfer and ureg-to-ureg instructions into
// RF / DAG / PS read ports (combinational) and write ports (through a
// WB_LAT-deep write-back pipe), with a read-after-write hazard stall.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ps_pshstck ..        instruction strobes (push, pop, imm, dm, ureg xfer)
//   ps_dm_wrb            DM direction (1 = ureg to DM)
//   ps_ureg1_add/2_add   ureg addresses from decode
//   ps_*_rd_add          per-group read addresses (0 when group unselected)
//   ps_*_wrt_en/_add     per-group write ports from the last pipe stage
//   ps_hzd_stall         RAW hazard against an in-flight write
//   ps_ureg_err          sticky illegal ureg / illegal combination flag
module ps_ureg_xfer_ctl #(
   parameter int         WB_LAT  = 1,
   parameter logic [4:0] STK_ADD = 5'b00100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps_pshstck,
   input  logic       ps_popstck,
   input  logic       ps_imminst,
   input  logic       ps_dminst,
   input  logic       ps_dm_wrb,
   input  logic       ps_urgtrnsinst,
   input  logic [7:0] ps_ureg1_add,
   input  logic [7:0] ps_ureg2_add,
   output logic [3:0] ps_rf_dm_rd_add,
   output logic [4:0] ps_dg_rd_add,
   output logic [4:0] ps_rd_add,
   output logic       ps_rf_dm_wrt_en,
   output logic       ps_dg_wrt_en,
   output logic       ps_wrt_en,
   output logic [3:0] ps_rf_dm_wrt_add,
   output logic [4:0] ps_dg_wrt_add,
   output logic [4:0] ps_wrt_add,
   output logic       ps_hzd_stall,
   output logic       ps_ureg_err
);

   typedef enum logic [1:0] {
      G_NONE = 2'd0,
      G_RF   = 2'd1,
      G_DG   = 2'd2,
      G_PS   = 2'd3
   } grp_e;

   typedef struct packed {
      logic       vld;
      grp_e       grp;
      logic [4:0] add;
   } wb_ent_t;

   // vld=0 marks an undefined group code
   function automatic wb_ent_t dec_ureg(input logic [7:0] ua);
      wb_ent_t e;
      e = '0;
      case (ua[7:4])
         4'h0: begin
            e.vld = 1'b1;
            e.grp = G_RF;
            e.add = {1'b0, ua[3:0]};
         end
         4'h1, 4'h2: begin
            e.vld = 1'b1;
            e.grp = G_DG;
            e.add = ua[4:0];
         end
         4'h6, 4'h7: begin
            e.vld = 1'b1;
            e.grp = G_PS;
            e.add = ua[4:0];
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   wb_ent_t u1_dec;
   wb_ent_t u2_dec;
   wb_ent_t rd_ent;
   wb_ent_t wr_req;
   wb_ent_t out_ent;
   wb_ent_t pipe_q [WB_LAT];
   wb_ent_t pipe_d [WB_LAT];
   logic    hzd;
   logic    any_inst;
   logic    err_q;
   logic    err_d;

   assign u1_dec = dec_ureg(ps_ureg1_add);
   assign u2_dec = dec_ureg(ps_ureg2_add);

   // read select, highest priority first
   always_comb begin
      rd_ent = '0;
      if (ps_pshstck || (ps_dminst && ps_dm_wrb)) begin
         rd_ent = u1_dec;
      end else if (ps_urgtrnsinst) begin
         rd_ent = u2_dec;
      end else if (ps_popstck) begin
         rd_ent = {1'b1, G_PS, STK_ADD};
      end
   end

   assign ps_rf_dm_rd_add = (rd_ent.grp == G_RF) ? rd_ent.add[3:0] : 4'h0;
   assign ps_dg_rd_add    = (rd_ent.grp == G_DG) ? rd_ent.add : 5'h00;
   assign ps_rd_add       = (rd_ent.grp == G_PS) ? rd_ent.add : 5'h00;

   // write request; pop outranks push so push+pop writes ureg1
   always_comb begin
      wr_req = '0;
      if (ps_popstck || ps_imminst || ps_urgtrnsinst ||
          (ps_dminst && !ps_dm_wrb)) begin
         wr_req = u1_dec;
      end else if (ps_pshstck) begin
         wr_req = {1'b1, G_PS, STK_ADD};
      end
   end

   // the output stage writes the bank at this edge, so it is skipped
   always_comb begin
      hzd = 1'b0;
      for (int i = 0; i < WB_LAT - 1; i++) begin
         if (rd_ent.vld && pipe_q[i].vld &&
             (pipe_q[i].grp == rd_ent.grp) &&
             (pipe_q[i].add == rd_ent.add)) begin
            hzd = 1'b1;
         end
      end
   end

   assign ps_hzd_stall = hzd;

   always_comb begin
      pipe_d[0] = hzd ? '0 : wr_req;
      for (int i = 1; i < WB_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   assign any_inst = ps_pshstck | ps_popstck | ps_imminst |
                     ps_dminst | ps_urgtrnsinst;

   always_comb begin
      err_d = err_q;
      if (any_inst && !u1_dec.vld) begin
         err_d = 1'b1;
      end
      if (ps_urgtrnsinst && !u2_dec.vld) begin
         err_d = 1'b1;
      end
      if (ps_pshstck && ps_popstck) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WB_LAT; i++) begin
            pipe_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < WB_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         err_q <= err_d;
      end
   end

   assign ps_ureg_err = err_q;
   assign out_ent     = pipe_q[WB_LAT-1];

   assign ps_rf_dm_wrt_en = out_ent.vld && (out_ent.grp == G_RF);
   assign ps_dg_wrt_en    = out_ent.vld && (out_ent.grp == G_DG);
   assign ps_wrt_en       = out_ent.vld && (out_ent.grp == G_PS);

   assign ps_rf_dm_wrt_add = ps_rf_dm_wrt_en ? out_ent.add[3:0] : 4'h0;
   assign ps_dg_wrt_add    = ps_dg_wrt_en ? out_ent.add : 5'h00;
   assign ps_wrt_add       = ps_wrt_en ? out_ent.add : 5'h00;

endmodule

// File: tb/tb_ps_ureg_xfer_ctl.sv
// Bench for ps_ureg_xfer_ctl: three instances (WB_LAT 1, 3, 4) share
// stimulus; directed table, hand sequences and random traffic vs a model.
module tb_ps_ureg_xfer_ctl;

   localparam int ND   = 3;
   localparam int MAXC = 4096;
   localparam int STK  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       push, pop, imm, dm, wrb, trn;
   logic [7:0] u1, u2;

   logic [3:0] rf_rd [ND];
   logic [4:0] dg_rd [ND];
   logic [4:0] ps_rd [ND];
   logic       wen_rf [ND];
   logic       wen_dg [ND];
   logic       wen_ps [ND];
   logic [3:0] wa_rf [ND];
   logic [4:0] wa_dg [ND];
   logic [4:0] wa_ps [ND];
   logic       stall [ND];
   logic       err [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      ps_ureg_xfer_ctl #(
         .WB_LAT  (g == 0 ? 1 : (g == 1 ? 3 : 4)),
         .STK_ADD (5'b00100)
      ) u_dut (
         .clk              (clk),
         .rst              (rst),
         .ps_pshstck       (push),
         .ps_popstck       (pop),
         .ps_imminst       (imm),
         .ps_dminst        (dm),
         .ps_dm_wrb        (wrb),
         .ps_urgtrnsinst   (trn),
         .ps_ureg1_add     (u1),
         .ps_ureg2_add     (u2),
         .ps_rf_dm_rd_add  (rf_rd[g]),
         .ps_dg_rd_add     (dg_rd[g]),
         .ps_rd_add        (ps_rd[g]),
         .ps_rf_dm_wrt_en  (wen_rf[g]),
         .ps_dg_wrt_en     (wen_dg[g]),
         .ps_wrt_en        (wen_ps[g]),
         .ps_rf_dm_wrt_add (wa_rf[g]),
         .ps_dg_wrt_add    (wa_dg[g]),
         .ps_wrt_add       (wa_ps[g]),
         .ps_hzd_stall     (stall[g]),
         .ps_ureg_err      (err[g])
      );
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   // ---------------- reference model ----------------
   // group: 0 none, 1 RF, 2 DAG, 3 PS
   typedef struct {
      bit v;
      int g;
      int a;
   } wr_t;

   wr_t hist [ND][MAXC];
   bit  err_m [ND];
   int  cyc = 0;
   bit  chk_en = 0;

   function automatic void dec(input logic [7:0] x,
                               output int g, output int ad);
      int hi;
      hi = int'(x) / 16;
      g  = 0;
      ad = 0;
      if (hi == 0) begin
         g = 1; ad = int'(x) % 16;
      end else if (hi == 1 || hi == 2) begin
         g = 2; ad = int'(x) % 32;
      end else if (hi == 6 || hi == 7) begin
         g = 3; ad = int'(x) % 32;
      end
   endfunction

   function automatic void m_read(output int g, output int ad);
      g = 0; ad = 0;
      if (push || (dm && wrb)) dec(u1, g, ad);
      else if (trn) dec(u2, g, ad);
      else if (pop) begin g = 3; ad = STK; end
   endfunction

   function automatic void m_wreq(output bit v, output int g,
                                  output int ad);
      v = 0; g = 0; ad = 0;
      if (pop || imm || trn || (dm && !wrb)) begin
         dec(u1, g, ad);
         v = (g != 0);
      end else if (push) begin
         v = 1; g = 3; ad = STK;
      end
   endfunction

   function automatic bit m_errc();
      int g1, a1, g2, a2;
      dec(u1, g1, a1);
      dec(u2, g2, a2);
      return ((push || pop || imm || dm || trn) && g1 == 0) ||
             (trn && g2 == 0) || (push && pop);
   endfunction

   // read conflicts with a write issued 1..L-1 cycles ago
   function automatic bit m_stall(input int d);
      int g, a;
      m_read(g, a);
      if (g == 0) return 0;
      for (int k = 1; k < lat_of(d); k++) begin
         if (cyc - k >= 0 && hist[d][cyc-k].v &&
             hist[d][cyc-k].g == g && hist[d][cyc-k].a == a)
            return 1;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      if (cyc < MAXC) begin
         bit v;
         int g, a;
         m_wreq(v, g, a);
         for (int d = 0; d < ND; d++) begin
            if (rst) begin
               for (int k = 0; k <= lat_of(d); k++)
                  if (cyc - k >= 0) hist[d][cyc-k].v = 0;
               err_m[d] = 0;
            end else begin
               if (m_stall(d)) begin
                  hist[d][cyc].v = 0;
               end else begin
                  hist[d][cyc].v = v;
                  hist[d][cyc].g = g;
                  hist[d][cyc].a = a;
               end
               err_m[d] = err_m[d] | m_errc();
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         int  rg, ra, L;
         wr_t w;
         m_read(rg, ra);
         for (int d = 0; d < ND; d++) begin
            L = lat_of(d);
            w.v = 0; w.g = 0; w.a = 0;
            if (cyc >= L) w = hist[d][cyc-L];
            chk($sformatf("m%0d.rf_rd@%0d", d, cyc), rf_rd[d],
                rg == 1 ? ra : 0);
            chk($sformatf("m%0d.dg_rd@%0d", d, cyc), dg_rd[d],
                rg == 2 ? ra : 0);
            chk($sformatf("m%0d.ps_rd@%0d", d, cyc), ps_rd[d],
                rg == 3 ? ra : 0);
            chk($sformatf("m%0d.wen_rf@%0d", d, cyc), wen_rf[d],
                int'(w.v && w.g == 1));
            chk($sformatf("m%0d.wen_dg@%0d", d, cyc), wen_dg[d],
                int'(w.v && w.g == 2));
            chk($sformatf("m%0d.wen_ps@%0d", d, cyc), wen_ps[d],
                int'(w.v && w.g == 3));
            chk($sformatf("m%0d.wa_rf@%0d", d, cyc), wa_rf[d],
                (w.v && w.g == 1) ? w.a : 0);
            chk($sformatf("m%0d.wa_dg@%0d", d, cyc), wa_dg[d],
                (w.v && w.g == 2) ? w.a : 0);
            chk($sformatf("m%0d.wa_ps@%0d", d, cyc), wa_ps[d],
                (w.v && w.g == 3) ? w.a : 0);
            chk($sformatf("m%0d.stall@%0d", d, cyc), stall[d],
                int'(m_stall(d)));
            chk($sformatf("m%0d.err@%0d", d, cyc), err[d],
                int'(err_m[d]));
         end
      end
   end

   // ---------------- directed vectors (WB_LAT=1 instance) ----------
   typedef struct {
      bit         rst, push, pop, imm, dm, wrb, trn;
      logic [7:0] u1, u2;
      int         rf, dg, ps;
      bit   [2:0] en;
      int         wrf, wdg, wps;
      bit         st, er;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   task automatic idle();
      rst = 0; push = 0; pop = 0; imm = 0;
      dm = 0; wrb = 0; trn = 0; u1 = 8'h00; u2 = 8'h00;
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; push = v.push; pop = v.pop; imm = v.imm;
      dm = v.dm; wrb = v.wrb; trn = v.trn; u1 = v.u1; u2 = v.u2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pick();
      logic [3:0] hi;
      int         r;
      r = $urandom_range(0, 9);
      if (r == 0) return 8'($urandom);
      case ($urandom_range(0, 4))
         0: hi = 4'h0;
         1: hi = 4'h1;
         2: hi = 4'h2;
         3: hi = 4'h6;
         default: hi = 4'h7;
      endcase
      return {hi, 4'($urandom_range(2, 5))};
   endfunction

   initial begin
      // rst push pop imm dm wrb trn u1 u2 | rf dg ps en wrf wdg wps st er
      tbl[0]  = '{1,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b000, 0,0,0, 0,0};
      tbl[1]  = '{0,0,0,1,0,0,0,8'h05,8'h00, 0,0,0, 3'b000, 0,0,0, 0,0};
      tbl[2]  = '{0,0,0,0,0,0,1,8'h13,8'h62, 0,0,2, 3'b100, 5,0,0, 0,0};
      tbl[3]  = '{0,1,0,0,0,0,0,8'h07,8'h00, 7,0,0, 3'b010, 0,19,0, 0,0};
      tbl[4]  = '{0,0,1,0,0,0,0,8'h0A,8'h00, 0,0,4, 3'b001, 0,0,4, 0,0};
      tbl[5]  = '{0,0,0,0,1,1,0,8'h25,8'h00, 0,5,0, 3'b100, 10,0,0, 0,0};
      tbl[6]  = '{0,0,0,0,1,0,0,8'h6F,8'h00, 0,0,0, 3'b000, 0,0,0, 0,0};
      tbl[7]  = '{0,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b001, 0,0,15, 0,0};
      tbl[8]  = '{0,0,0,1,0,0,0,8'h35,8'h00, 0,0,0, 3'b000, 0,0,0, 0,0};
      tbl[9]  = '{0,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b000, 0,0,0, 0,1};
      tbl[10] = '{1,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b000, 0,0,0, 0,1};
      tbl[11] = '{0,1,1,0,0,0,0,8'h01,8'h00, 1,0,0, 3'b000, 0,0,0, 0,0};
      tbl[12] = '{0,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b100, 1,0,0, 0,1};
      tbl[13] = '{1,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b000, 0,0,0, 0,1};
      tbl[14] = '{0,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b000, 0,0,0, 0,0};
      tbl[15] = '{0,0,0,0,0,0,1,8'h1F,8'h7F, 0,0,31, 3'b000, 0,0,0, 0,0};
      tbl[16] = '{0,0,0,0,0,0,0,8'h00,8'h00, 0,0,0, 3'b010, 0,31,0, 0,0};

      idle();
      rst = 1;
      step();
      chk_en = 1;
      step();

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("t%0d.rf_rd", i), rf_rd[0], tbl[i].rf);
         chk($sformatf("t%0d.dg_rd", i), dg_rd[0], tbl[i].dg);
         chk($sformatf("t%0d.ps_rd", i), ps_rd[0], tbl[i].ps);
         chk($sformatf("t%0d.wen", i),
             int'({wen_rf[0], wen_dg[0], wen_ps[0]}), int'(tbl[i].en));
         chk($sformatf("t%0d.wa_rf", i), wa_rf[0], tbl[i].wrf);
         chk($sformatf("t%0d.wa_dg", i), wa_dg[0], tbl[i].wdg);
         chk($sformatf("t%0d.wa_ps", i), wa_ps[0], tbl[i].wps);
         chk($sformatf("t%0d.stall", i), stall[0], int'(tbl[i].st));
         chk($sformatf("t%0d.err", i), err[0], int'(tbl[i].er));
         step();
      end

      // RAW hazard: WB_LAT=3 stalls 2 cycles, WB_LAT=4 stalls 3
      idle();
      repeat (5) step();
      imm = 1; u1 = 8'h71;
      @(negedge clk);
      chk("raw.s0.st3", stall[1], 0);
      step();
      idle();
      trn = 1; u1 = 8'h05; u2 = 8'h71;
      @(negedge clk);
      chk("raw.s1.st3", stall[1], 1);
      chk("raw.s1.st4", stall[2], 1);
      step();
      @(negedge clk);
      chk("raw.s2.st3", stall[1], 1);
      chk("raw.s2.st4", stall[2], 1);
      step();
      @(negedge clk);
      chk("raw.s3.st3", stall[1], 0);
      chk("raw.s3.wen3", wen_ps[1], 1);
      chk("raw.s3.wa3", wa_ps[1], 17);
      chk("raw.s3.st4", stall[2], 1);
      step();
      @(negedge clk);
      chk("raw.s4.st4", stall[2], 0);
      chk("raw.s4.wa4", wa_ps[2], 17);
      step();
      idle();
      repeat (6) step();
      imm = 1; u1 = 8'h71;
      step();
      idle();
      trn = 1; u1 = 8'h05; u2 = 8'h70;
      @(negedge clk);
      chk("raw.nm.st3", stall[1], 0);
      chk("raw.nm.st4", stall[2], 0);
      step();

      // reset with three writes in flight, WB_LAT=4
      idle();
      repeat (6) step();
      for (int i = 1; i <= 3; i++) begin
         imm = 1; u1 = 8'(i);
         step();
      end
      idle();
      rst = 1;
      @(negedge clk);
      chk("rst.c3.wen_rf", wen_rf[2], 0);
      step();
      rst = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("rst.c%0d.wen", i + 4),
             int'({wen_rf[2], wen_dg[2], wen_ps[2]}), 0);
         chk($sformatf("rst.c%0d.wa_rf", i + 4), wa_rf[2], 0);
         step();
      end

      // random traffic, checked against the model every cycle
      for (int n = 0; n < 2000; n++) begin
         idle();
         rst = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 7))
            0: ;
            1: push = 1;
            2: pop = 1;
            3: imm = 1;
            4: dm = 1;
            5, 6: trn = 1;
            default: begin
               push = 1'($urandom); pop = 1'($urandom);
               imm = 1'($urandom); dm = 1'($urandom);
               trn = 1'($urandom);
            end
         endcase
         wrb = 1'($urandom);
         u1 = pick();
         u2 = pick();
         step();
      end
      idle();
      step();
      @(negedge clk);
      chk_en = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
